// File: rtl/mem_access_unit.sv
// Memory-stage access controller: issues word-aligned loads/stores to a multi-cycle
// data memory, stalls the pipeline while the access is outstanding, and flags sticky errors.
module mem_access_unit #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [ADDR_W-1:0] aluResult,
  input  logic [ADDR_W-1:0] storeData,
  input  logic              memBusy,
  input  logic              memDone,
  input  logic [ADDR_W-1:0] memDataIn,
  output logic              memRd,
  output logic              memWr,
  output logic [ADDR_W-1:0] memAddr,
  output logic [ADDR_W-1:0] memDataOut,
  output logic [ADDR_W-1:0] readData,
  output logic              dataValid,
  output logic              stallPipe,
  output logic              err,
  output logic [1:0]        errCode
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } stateT;

  localparam logic [1:0] ERR_MISALIGNED = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT    = 2'b10;

  stateT      state;
  stateT      stateNext;
  logic [7:0] waitCnt;
  logic       isLoad;
  logic       access;
  logic       captureReq;
  logic       captureLoad;
  logic       cntInc;
  logic       setErr;
  logic [1:0] errCodeNext;

  // Memory is word-addressed in bytes pairs, so any odd byte address is illegal.
  function automatic logic misaligned(input logic [ADDR_W-1:0] addr);
    return (addr & ADDR_W'(1)) != '0;
  endfunction

  // The edge that would move the count to TIMEOUT ends the wait.
  function automatic logic timeoutHit(input logic [7:0] cnt);
    return cnt == 8'(TIMEOUT - 1);
  endfunction

  assign access = valid & (memRead | memWrite);

  always_comb begin
    stateNext   = state;
    stallPipe   = 1'b0;
    captureReq  = 1'b0;
    captureLoad = 1'b0;
    cntInc      = 1'b0;
    setErr      = 1'b0;
    errCodeNext = 2'b00;
    case (state)
      IDLE: begin
        if (access) begin
          stallPipe = 1'b1;
          if (misaligned(aluResult)) begin
            stateNext   = ERR;
            setErr      = 1'b1;
            errCodeNext = ERR_MISALIGNED;
          end else if (!memBusy) begin
            stateNext  = ISSUE;
            captureReq = 1'b1;
          end
        end
      end
      ISSUE: begin
        stallPipe = 1'b1;
        stateNext = WAIT;
      end
      WAIT: begin
        stallPipe = 1'b1;
        // Completion wins over a timeout landing on the same edge.
        if (memDone) begin
          stateNext   = DONE;
          captureLoad = isLoad;
        end else if (timeoutHit(waitCnt)) begin
          stateNext   = ERR;
          setErr      = 1'b1;
          errCodeNext = ERR_TIMEOUT;
        end else begin
          cntInc = 1'b1;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      ERR: begin
        stallPipe = 1'b1;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign memRd     = (state == ISSUE) &  isLoad;
  assign memWr     = (state == ISSUE) & ~isLoad;
  assign dataValid = (state == DONE);
  assign err       = (state == ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      waitCnt    <= '0;
      isLoad     <= 1'b0;
      memAddr    <= '0;
      memDataOut <= '0;
      readData   <= '0;
      errCode    <= '0;
    end else begin
      state <= stateNext;
      // A simultaneous load+store is treated as a load.
      if (captureReq) begin
        memAddr    <= aluResult;
        memDataOut <= storeData;
        isLoad     <= memRead;
      end
      if (state == ISSUE) begin
        waitCnt <= '0;
      end else if (cntInc) begin
        waitCnt <= waitCnt + 8'd1;
      end
      if (captureLoad) begin
        readData <= memDataIn;
      end
      if (setErr) begin
        errCode <= errCodeNext;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected requests and completions are queued by
// the driver and checked by an independent monitor; error paths are checked inline.
module tb_mem_access_unit;
  localparam int AW = 16;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid, memRead, memWrite, memBusy, memDone;
  logic [AW-1:0] aluResult, storeData, memDataIn;
  logic          memRd, memWr, dataValid, stallPipe, err;
  logic [AW-1:0] memAddr, memDataOut, readData;
  logic [1:0]    errCode;

  mem_access_unit #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid(valid), .memRead(memRead), .memWrite(memWrite),
    .aluResult(aluResult), .storeData(storeData), .memBusy(memBusy), .memDone(memDone),
    .memDataIn(memDataIn), .memRd(memRd), .memWr(memWr), .memAddr(memAddr),
    .memDataOut(memDataOut), .readData(readData), .dataValid(dataValid),
    .stallPipe(stallPipe), .err(err), .errCode(errCode)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          isWrite;
    logic [AW-1:0] addr;
    logic [AW-1:0] data;
  } reqT;

  reqT           reqQ[$];
  logic [AW-1:0] cplQ[$];
  logic [AW-1:0] modelRead;
  reqT           monReq;
  logic [AW-1:0] monCpl;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every request strobe and every completion must match the next expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (memRd || memWr) begin
        if (reqQ.size() == 0) begin
          check("unexpectedReq", {memRd, memWr}, 2'b00);
        end else begin
          monReq = reqQ.pop_front();
          check("reqWr", memWr, monReq.isWrite);
          check("reqRd", memRd, !monReq.isWrite);
          check("reqAddr", memAddr, monReq.addr);
          if (monReq.isWrite) check("reqData", memDataOut, monReq.data);
        end
      end
      if (dataValid) begin
        if (cplQ.size() == 0) begin
          check("unexpectedDataValid", dataValid, 1'b0);
        end else begin
          monCpl = cplQ.pop_front();
          check("readData", readData, monCpl);
          check("doneStall", stallPipe, 1'b0);
          check("doneErr", err, 1'b0);
        end
      end
    end
  end

  task automatic doReset();
    rst = 1'b1; valid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    memBusy = 1'b0; memDone = 1'b0;
    repeat (2) @(negedge clk);
    check("rstStrobes", {memRd, memWr, dataValid}, 3'b000);
    check("rstStallErr", {stallPipe, err}, 2'b00);
    check("rstErrCode", errCode, 2'b00);
    check("rstReadData", readData, '0);
    check("rstMemAddr", memAddr, '0);
    check("rstMemDataOut", memDataOut, '0);
    reqQ.delete();
    cplQ.delete();
    modelRead = '0;
    rst = 1'b0;
  endtask

  // Present one aligned access; returns after the DONE cycle (or on a missing strobe).
  task automatic doAccess(input bit rd, input bit wr, input logic [AW-1:0] addr,
                          input logic [AW-1:0] sdata, input logic [AW-1:0] rdata,
                          input int busy, input int n, input bit expectDone);
    reqT r;
    bit  found;
    bit  isLoad;
    isLoad    = rd;
    r.isWrite = !isLoad;
    r.addr    = addr;
    r.data    = sdata;
    reqQ.push_back(r);
    if (expectDone) begin
      if (isLoad) modelRead = rdata;
      cplQ.push_back(modelRead);
    end
    valid = 1'b1; memRead = rd; memWrite = wr; aluResult = addr; storeData = sdata;
    memDone = 1'b0; memBusy = (busy > 0);
    for (int i = 0; i < busy; i++) begin
      @(negedge clk);
      check("busyNoReq", {memRd, memWr}, 2'b00);
      check("busyStall", stallPipe, 1'b1);
      if (i == busy - 1) memBusy = 1'b0;
    end
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (memRd || memWr) found = 1'b1;
    end
    if (!found) begin
      check("strobeSeen", memRd | memWr, 1'b1);
      valid = 1'b0;
      return;
    end
    check("issueStall", stallPipe, 1'b1);
    if (!expectDone) return;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      check("waitStall", stallPipe, 1'b1);
      check("waitNoValid", dataValid, 1'b0);
      if (j == n) begin
        memDone = 1'b1;
        memDataIn = rdata;
      end
    end
    @(negedge clk);
    check("doneValid", dataValid, 1'b1);
    memDone = 1'b0; valid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    memDataIn = AW'($urandom);
  endtask

  // Non-access cycles with stray memDone: nothing may happen.
  task automatic idleJunk(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      valid = 1'($urandom);
      if (valid) begin
        memRead = 1'b0; memWrite = 1'b0;
      end else begin
        memRead = 1'($urandom); memWrite = 1'($urandom);
      end
      memBusy = 1'($urandom); memDone = 1'($urandom); memDataIn = AW'($urandom);
      aluResult = AW'($urandom);
      @(negedge clk);
      check("idleStall", stallPipe, 1'b0);
      check("idleReadData", readData, modelRead);
    end
    valid = 1'b0; memRead = 1'b0; memWrite = 1'b0; memBusy = 1'b0; memDone = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    aluResult = '0; storeData = '0; memDataIn = '0;
    @(negedge clk);
    doReset();

    // Directed load, store under busy, back-to-back loads, load+store as load.
    doAccess(1, 0, 16'h0010, 16'h0000, 16'hBEEF, 0, 1, 1);
    check("loadHold", readData, 16'hBEEF);
    doAccess(0, 1, 16'h0042, 16'h1234, 16'h5A5A, 3, 2, 1);
    doAccess(1, 0, 16'h0020, 16'h0000, 16'h0001, 0, 1, 1);
    doAccess(1, 0, 16'h0022, 16'h0000, 16'h0002, 0, 1, 1);
    doAccess(1, 1, 16'h0100, 16'h7777, 16'hC0DE, 1, 3, 1);
    // Completion on the last permitted wait cycle.
    doAccess(1, 0, 16'h0200, 16'h0000, 16'hF00D, 0, TO, 1);
    check("lateDoneNoErr", err, 1'b0);

    // Timeout: strobe in cycle t, WAIT t+1..t+TO, ERR from t+TO+1.
    doAccess(1, 0, 16'h0300, 16'h0000, 16'h0000, 0, 0, 0);
    for (int j = 1; j <= TO + 1; j++) begin
      @(negedge clk);
      if (j <= TO) check("toNotYet", err, 1'b0);
    end
    check("toErr", err, 1'b1);
    check("toCode", errCode, 2'b10);
    check("toStall", stallPipe, 1'b1);
    memDone = 1'b1; memDataIn = 16'h9999;
    repeat (2) @(negedge clk);
    memDone = 1'b0;
    check("toSticky", {err, errCode}, 3'b110);
    check("toReadData", readData, 16'hF00D);
    doReset();

    // Misaligned load, then misaligned store with busy memory.
    for (int m = 0; m < 2; m++) begin
      valid = 1'b1; memRead = (m == 0); memWrite = (m == 1);
      aluResult = (m == 0) ? 16'h0011 : 16'h0043; memBusy = (m == 1);
      @(negedge clk);
      check("misErr", err, 1'b1);
      check("misCode", errCode, 2'b01);
      valid = 1'b0; memRead = 1'b0; memWrite = 1'b0; memBusy = 1'b0;
      repeat (3) @(negedge clk);
      check("misSticky", {err, stallPipe, errCode}, 4'b1101);
      doReset();
    end

    // Reset mid-WAIT after a load has set readData; later memDone ignored.
    doAccess(1, 0, 16'h0040, 16'h0000, 16'hABCD, 0, 1, 1);
    doAccess(1, 0, 16'h0044, 16'h0000, 16'h0000, 0, 0, 0);
    repeat (2) @(negedge clk);
    doReset();
    memDone = 1'b1; memDataIn = 16'hAAAA;
    repeat (2) @(negedge clk);
    memDone = 1'b0;
    check("postRstReadData", readData, 16'h0000);
    check("postRstNoValid", dataValid, 1'b0);

    // Randomized traffic with junk idle cycles in between.
    for (int t = 0; t < 40; t++) begin
      int            kind;
      logic [AW-1:0] a;
      kind = $urandom_range(0, 2);
      a = AW'($urandom) & 16'hFFFE;
      doAccess(kind != 1, kind != 0, a, AW'($urandom), AW'($urandom),
               $urandom_range(0, 3), $urandom_range(1, TO), 1);
      idleJunk($urandom_range(0, 2));
    end

    repeat (3) @(negedge clk);
    check("reqQEmpty", reqQ.size(), 0);
    check("cplQEmpty", cplQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
